// File: rtl/ulpi_phy_responder.sv
// ulpi_phy_responder: PHY-side ULPI bus end that acks link TX CMD bytes and turns the bus around for RX packets.
// Optional ULPI_PHY_STALL_EN adds LFSR-driven random stalls before nxt is raised on TX.
module ulpi_phy_responder #(
  parameter int NXT_DELAY     = 1,
  parameter int RX_IDLE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  input  logic [7:0] ulpi_data_i,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_last,
  output logic       rx_ready,
  input  logic [7:0] rx_cmd,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       busy
);
  localparam logic [3:0] DLY = NXT_DELAY[3:0];
  localparam logic [5:0] LIM = RX_IDLE_LIMIT[5:0];
  // Each RX state is named for what the bus shows during it; RXDATA opens with the RX CMD byte
  // while the first packet byte is already being consumed, and RXLAST shows the final byte or fill.
  typedef enum logic [2:0] {IDLE, TX_WAIT, TX_ACK, TURN_OUT, RXDATA, RXLAST, TURN_IN} state_t;
  state_t state;
  logic [3:0] dcnt;
  logic [4:0] icnt;
  logic go;
  logic abort;
`ifdef ULPI_PHY_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  always_comb go = lfsr[0];
`else
  always_comb go = 1'b1;
`endif
  always_comb begin
    rx_ready = state == RXDATA;
    busy = state != IDLE;
    abort = LIM != 6'd0 && ({1'b0, icnt} + 6'd1) == LIM;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ulpi_dir <= 1'b0;
      ulpi_nxt <= 1'b0;
      ulpi_data_o <= 8'd0;
      ulpi_data_oe <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data <= 8'd0;
      dcnt <= 4'd0;
      icnt <= 5'd0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        IDLE:
          if (ulpi_data_i != 8'd0) begin
            if (DLY == 4'd0 && go) begin
              ulpi_nxt <= 1'b1;
              state <= TX_ACK;
            end else begin
              dcnt <= DLY == 4'd0 ? 4'd0 : DLY - 4'd1;
              state <= TX_WAIT;
            end
          end else if (rx_valid) begin
            ulpi_dir <= 1'b1;
            ulpi_data_oe <= 1'b0;
            state <= TURN_OUT;
          end
        TX_WAIT:
          if (ulpi_data_i == 8'd0) state <= IDLE;
          else if (dcnt == 4'd0 && go) begin
            ulpi_nxt <= 1'b1;
            state <= TX_ACK;
          end else if (dcnt != 4'd0) dcnt <= dcnt - 4'd1;
        TX_ACK: begin
          cmd_data <= ulpi_data_i;
          cmd_valid <= 1'b1;
          ulpi_nxt <= 1'b0;
          state <= IDLE;
        end
        TURN_OUT: begin
          ulpi_data_oe <= 1'b1;
          ulpi_data_o <= rx_cmd;
          ulpi_nxt <= 1'b0;
          icnt <= 5'd0;
          state <= RXDATA;
        end
        RXDATA:
          if (rx_valid) begin
            ulpi_data_o <= rx_data;
            ulpi_nxt <= 1'b1;
            icnt <= 5'd0;
            if (rx_last) state <= RXLAST;
          end else begin
            ulpi_data_o <= rx_cmd;
            ulpi_nxt <= 1'b0;
            icnt <= icnt == 5'd31 ? 5'd31 : icnt + 5'd1;
            if (abort) state <= RXLAST;
          end
        RXLAST: begin
          ulpi_dir <= 1'b0;
          ulpi_data_oe <= 1'b0;
          ulpi_nxt <= 1'b0;
          ulpi_data_o <= 8'd0;
          state <= TURN_IN;
        end
        TURN_IN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb_ulpi_phy_responder: scoreboard bench with a packet-level bus model; directed scenarios then random TX/RX traffic.
module tb_ulpi_phy_responder;
  localparam int ND = 1;
  localparam int LIM = 3;
  logic clk = 1'b0;
  logic reset_n;
  logic ulpi_dir, ulpi_nxt, ulpi_data_oe, rx_ready, cmd_valid, busy;
  logic [7:0] ulpi_data_o, cmd_data;
  logic [7:0] ulpi_data_i, rx_data, rx_cmd;
  logic rx_valid, rx_last;
  int checks = 0;
  int failures = 0;
  int dir_cnt = 0;
  logic [8:0] exp_bus[$];
  logic [7:0] exp_cmd[$];
  logic [7:0] pkt_b[$];
  int pkt_g[$];
  logic [8:0] eb;
  logic [7:0] ec;

  always #5 clk = ~clk;

  ulpi_phy_responder #(.NXT_DELAY(ND), .RX_IDLE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe), .ulpi_data_i(ulpi_data_i),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
    .rx_cmd(rx_cmd), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (ulpi_dir) dir_cnt++;
    if (ulpi_dir && ulpi_data_oe) begin
      if (exp_bus.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_extra actual=%0h required=none", {ulpi_nxt, ulpi_data_o});
      end else begin
        eb = exp_bus.pop_front();
        chk("bus_byte", 32'({ulpi_nxt, ulpi_data_o}), 32'(eb));
      end
    end else chk("rx_ready_off_bus", 32'(rx_ready), 0);
    if (ulpi_dir && !ulpi_data_oe) chk("turn_nxt", 32'(ulpi_nxt), 0);
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cmd_extra actual=%0h required=none", cmd_data);
      end else begin
        ec = exp_cmd.pop_front();
        chk("cmd_byte", 32'(cmd_data), 32'(ec));
      end
    end
  end

  task automatic tx_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    exp_cmd.push_back(b);
    ulpi_data_i = b;
    do begin
      @(negedge clk);
      n++;
      if (!ulpi_nxt) chk("tx_dir_low", 32'(ulpi_dir), 0);
    end while (!ulpi_nxt && n < 200);
    chk("tx_nxt_seen", 32'(ulpi_nxt), 1);
`ifndef ULPI_PHY_STALL_EN
    chk("tx_latency", 32'(n), 32'(ND + 2));
`endif
    @(posedge clk); #1;
    ulpi_data_i = 8'd0;
    @(negedge clk);
    chk("tx_nxt_pulse", 32'(ulpi_nxt), 0);
    chk("tx_cmd_next", 32'(cmd_valid), 1);
  endtask

  task automatic tx_abort(input logic [7:0] b);
    @(posedge clk); #1;
    ulpi_data_i = b;
    @(posedge clk); #1;
    ulpi_data_i = 8'd0;
    repeat (4) begin
      @(negedge clk);
      chk("txab_nxt", 32'(ulpi_nxt), 0);
    end
  endtask

  // Packet-level model: RX CMD, then each byte with one fill per idle cycle before it; an idle run
  // reaching LIM ends the packet after LIM fills and leaves later bytes unconsumed.
  task automatic rx_pkt(input logic [7:0] c);
    int n = pkt_b.size();
    int xfers = 0, exp_x = 0, fills = 0, to;
    bit seen = 0;
    exp_bus.push_back({1'b0, c});
    for (int i = 0; i < n; i++) begin
      if (i > 0 && pkt_g[i] >= LIM) begin
        for (int k = 0; k < LIM; k++) exp_bus.push_back({1'b0, c});
        fills += LIM;
        break;
      end
      if (i > 0) begin
        for (int k = 0; k < pkt_g[i]; k++) exp_bus.push_back({1'b0, c});
        fills += pkt_g[i];
      end
      exp_bus.push_back({1'b1, pkt_b[i]});
      exp_x++;
    end
    @(posedge clk); #1;
    dir_cnt = 0;
    rx_cmd = c;
    rx_valid = 1'b1;
    rx_data = pkt_b[0];
    rx_last = n == 1;
    for (int i = 0; i < n; i++) begin
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!rx_ready && to < 200);
      if (!rx_ready) begin
        chk("rx_ready_wait", 32'(rx_ready), 1);
        break;
      end
      @(posedge clk); #1;
      xfers++;
      if (i + 1 == n || pkt_g[i + 1] >= LIM) break;
      if (pkt_g[i + 1] > 0) begin
        rx_valid = 1'b0;
        repeat (pkt_g[i + 1]) @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_data = pkt_b[i + 1];
      rx_last = i + 2 == n;
    end
    rx_valid = 1'b0;
    rx_last = 1'b0;
    to = 0;
    while (busy && to < 200) begin
      @(negedge clk);
      to++;
      if (busy && !ulpi_dir) seen = 1;
    end
    chk("rx_busy_drop", 32'(busy), 0);
    chk("rx_dir_after", 32'(ulpi_dir), 0);
    chk("rx_turn_in", 32'(seen), 1);
    chk("rx_xfers", 32'(xfers), 32'(exp_x));
    chk("rx_dir_cycles", 32'(dir_cnt), 32'(2 + fills + exp_x));
  endtask

  task automatic set_pkt4(input int g2);
    pkt_b = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    pkt_g = {0, 0, g2, 0};
  endtask

  initial begin
    int to, n;
    reset_n = 1'b0;
    ulpi_data_i = 8'd0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    rx_last = 1'b0;
    rx_cmd = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dir", 32'(ulpi_dir), 0);
    chk("rst_nxt", 32'(ulpi_nxt), 0);
    chk("rst_data_o", 32'(ulpi_data_o), 0);
    chk("rst_oe", 32'(ulpi_data_oe), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_data", 32'(cmd_data), 0);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    tx_byte(8'h23);
    set_pkt4(0);
    rx_pkt(8'h0C);
    set_pkt4(2);
    rx_pkt(8'h0C);
    set_pkt4(0);
    fork
      tx_byte(8'h42);
      rx_pkt(8'h0C);
    join
    @(posedge clk); #1;
    rx_cmd = 8'h0C;
    rx_valid = 1'b1;
    rx_data = 8'hA1;
    exp_bus.push_back({1'b0, 8'h0C});
    exp_bus.push_back({1'b1, 8'hA1});
    for (int i = 0; i < 2; i++) begin
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!rx_ready && to < 200);
      chk("rst_rx_ready_wait", 32'(rx_ready), 1);
      @(posedge clk); #1;
      rx_data = 8'hA2;
    end
    reset_n = 1'b0;
    #1;
    chk("arst_dir", 32'(ulpi_dir), 0);
    chk("arst_nxt", 32'(ulpi_nxt), 0);
    chk("arst_oe", 32'(ulpi_data_oe), 0);
    chk("arst_rx_ready", 32'(rx_ready), 0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("arst_busy", 32'(busy), 0);
    tx_byte(8'hF0);
    pkt_b = {8'hA1, 8'hA2, 8'hA3};
    pkt_g = {0, 100, 0};
    rx_pkt(8'h0C);
    repeat (4) begin
      @(negedge clk);
      chk("abort_rx_ready", 32'(rx_ready), 0);
    end
    tx_abort(8'h55);
    repeat (40) begin
      case ($urandom_range(0, 2))
        0: tx_byte(8'($urandom_range(1, 255)));
        1: tx_abort(8'($urandom_range(1, 255)));
        default: begin
          n = $urandom_range(1, 6);
          pkt_b = {};
          pkt_g = {};
          for (int i = 0; i < n; i++) begin
            pkt_b.push_back(8'($urandom_range(0, 255)));
            pkt_g.push_back(i == 0 ? 0 : $urandom_range(0, LIM - 1));
          end
          rx_pkt(8'($urandom_range(0, 255)));
        end
      endcase
    end
    repeat (3) @(negedge clk);
    chk("bus_queue_empty", 32'(exp_bus.size()), 0);
    chk("cmd_queue_empty", 32'(exp_cmd.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
